// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_seq : EX-stage sequencer for the shared multiply / divide cores.    |
// | Optional MADD/MSUB accumulate is built when MULDIV_ACC_EN is defined.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+

`ifndef INST_MULT
`define INST_MULT  8'h18
`define INST_MULTU 8'h19
`define INST_DIV   8'h1A
`define INST_DIVU  8'h1B
`define INST_MADD  8'h1C
`define INST_MADDU 8'h1D
`define INST_MSUB  8'h1E
`define INST_MSUBU 8'h1F
`endif

module muldiv_seq #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flush,
  input  logic [7:0]  inst,
  input  logic        inst_valid,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [63:0] hilo_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [63:0] hilo_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_res_i,
  output logic        div_start_o,
  output logic        div_abort_o,
  output logic [31:0] div_z_o,
  output logic [31:0] div_d_o,
  input  logic [31:0] div_q_i,
  input  logic [31:0] div_r_i,
  input  logic        div_done_i,
  output logic        busy_o
);

  localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_TERM = CW'(DIV_CYCLES);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MUL_WAIT = 3'd1;
  localparam logic [2:0] DIV_WAIT = 3'd2;
  localparam logic [2:0] DONE     = 3'd4;
`ifdef MULDIV_ACC_EN
  localparam logic [2:0] ACC      = 3'd3;
`endif

  logic [2:0]    state, state_nxt;
  logic [31:0]   a_mag, b_mag;
  logic          neg_q, neg_r, suppress, div_first;
  logic [CW-1:0] cnt;
  logic [63:0]   result;

  logic op_mul, op_div, op_acc, op_sub, op_signed, accept, div_timeout;
  logic [63:0] mul_fix;
  logic [31:0] q_fix, r_fix;

`ifdef MULDIV_ACC_EN
  logic kind_acc, kind_sub;
`else
  logic unused_hilo;
  assign unused_hilo = ^hilo_i;
`endif

  always_comb begin
    op_mul    = (inst == `INST_MULT) || (inst == `INST_MULTU);
    op_div    = (inst == `INST_DIV)  || (inst == `INST_DIVU);
    op_signed = (inst == `INST_MULT) || (inst == `INST_DIV);
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`ifdef MULDIV_ACC_EN
    op_acc    = (inst == `INST_MADD) || (inst == `INST_MADDU) ||
                (inst == `INST_MSUB) || (inst == `INST_MSUBU);
    op_sub    = (inst == `INST_MSUB) || (inst == `INST_MSUBU);
    op_signed = op_signed || (inst == `INST_MADD) || (inst == `INST_MSUB);
`endif
  end

  assign accept      = (state == IDLE) && inst_valid && !exception_flush &&
                       (op_mul || op_div || op_acc);
  assign mul_fix     = neg_q ? -mul_res_i : mul_res_i;
  assign q_fix       = neg_q ? -div_q_i : div_q_i;
  assign r_fix       = neg_r ? -div_r_i : div_r_i;
  // A done arriving on the terminal-count cycle still wins over the watchdog.
  assign div_timeout = (cnt == DIV_TERM) && !div_done_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_div) state_nxt = (op2 == 32'd0) ? DONE : DIV_WAIT;
          else        state_nxt = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (exception_flush) state_nxt = IDLE;
`ifdef MULDIV_ACC_EN
        else if (cnt == '0) state_nxt = kind_acc ? ACC : DONE;
`else
        else if (cnt == '0) state_nxt = DONE;
`endif
      end
      DIV_WAIT: begin
        if (exception_flush)               state_nxt = IDLE;
        else if (div_done_i || div_timeout) state_nxt = DONE;
      end
`ifdef MULDIV_ACC_EN
      ACC:      state_nxt = exception_flush ? IDLE : DONE;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    hilo_we_o   = 1'b0;
    hilo_o      = 64'd0;
    div_start_o = 1'b0;
    div_abort_o = 1'b0;
    case (state)
      IDLE:     stall_o = accept;
      MUL_WAIT: stall_o = 1'b1;
      DIV_WAIT: begin
        stall_o     = 1'b1;
        div_start_o = div_first;
        div_abort_o = exception_flush || div_timeout;
      end
`ifdef MULDIV_ACC_EN
      ACC:      stall_o = 1'b1;
`endif
      DONE: begin
        hilo_we_o = !suppress && !exception_flush;
        hilo_o    = result;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state != IDLE);
  assign mul_a_o = a_mag;
  assign mul_b_o = b_mag;
  assign div_z_o = a_mag;
  assign div_d_o = b_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag     <= 32'd0;
      b_mag     <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      suppress  <= 1'b0;
      div_first <= 1'b0;
      cnt       <= '0;
      result    <= 64'd0;
`ifdef MULDIV_ACC_EN
      kind_acc  <= 1'b0;
      kind_sub  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_mag     <= (op_signed && op1[31]) ? -op1 : op1;
            b_mag     <= (op_signed && op2[31]) ? -op2 : op2;
            neg_q     <= op_signed && (op1[31] ^ op2[31]);
            neg_r     <= op_signed && op1[31];
            suppress  <= op_div && (op2 == 32'd0);
            div_first <= 1'b1;
            cnt       <= op_div ? '0 : MUL_LOAD;
`ifdef MULDIV_ACC_EN
            kind_acc  <= op_acc;
            kind_sub  <= op_sub;
`endif
          end
        end
        MUL_WAIT: begin
          // The signed product doubles as the accumulate operand for ACC.
          if (cnt == '0) result <= mul_fix;
          else           cnt    <= cnt - 1'b1;
        end
        DIV_WAIT: begin
          div_first <= 1'b0;
          if (div_done_i)        result   <= {r_fix, q_fix};
          else if (div_timeout)  suppress <= 1'b1;
          else                   cnt      <= cnt + 1'b1;
        end
`ifdef MULDIV_ACC_EN
        ACC: result <= kind_sub ? (hilo_i - result) : (hilo_i + result);
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// Testbench for muldiv_seq: directed vector table plus hand-written corner sequences.

`ifndef INST_MULT
`define INST_MULT  8'h18
`define INST_MULTU 8'h19
`define INST_DIV   8'h1A
`define INST_DIVU  8'h1B
`define INST_MADD  8'h1C
`define INST_MADDU 8'h1D
`define INST_MSUB  8'h1E
`define INST_MSUBU 8'h1F
`endif

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_flush;
  logic [7:0]  inst;
  logic        inst_valid;
  logic [31:0] op1, op2;
  logic [63:0] hilo_i;
  logic        stall_o, hilo_we_o, div_start_o, div_abort_o, div_done_i, busy_o;
  logic [63:0] hilo_o, mul_res_i;
  logic [31:0] mul_a_o, mul_b_o, div_z_o, div_d_o, div_q_i, div_r_i;

  int checks = 0;
  int failures = 0;

  muldiv_seq #(.MUL_CYCLES(2), .DIV_CYCLES(36)) dut (
    .clk(clk), .rst(rst), .exception_flush(exception_flush),
    .inst(inst), .inst_valid(inst_valid), .op1(op1), .op2(op2), .hilo_i(hilo_i),
    .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hilo_o(hilo_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_res_i(mul_res_i),
    .div_start_o(div_start_o), .div_abort_o(div_abort_o),
    .div_z_o(div_z_o), .div_d_o(div_d_o), .div_q_i(div_q_i), .div_r_i(div_r_i),
    .div_done_i(div_done_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Core models: combinational multiplier, divider answering div_delay cycles after start.
  int          cyc = 0;
  int          done_cyc = -1;
  int          div_delay = 0;
  int          we_count = 0;
  logic [31:0] mz = 32'd0, md = 32'd0;

  assign mul_res_i  = {32'd0, mul_a_o} * {32'd0, mul_b_o};
  assign div_done_i = (cyc == done_cyc);
  assign div_q_i    = (md != 32'd0) ? mz / md : 32'd0;
  assign div_r_i    = (md != 32'd0) ? mz % md : 32'd0;

  always @(posedge clk) begin
    if (div_start_o) begin
      done_cyc <= cyc + div_delay;
      mz       <= div_z_o;
      md       <= div_d_o;
    end
    if (hilo_we_o) we_count <= we_count + 1;
    cyc <= cyc + 1;
  end

  typedef struct {
    logic [7:0]  inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] h;
    int          dly;
    int          flush_at;
    int          exp_lat;
    int          exp_we;
    logic [63:0] exp_data;
    int          exp_abort;
    int          exp_start;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Presents one instruction, holding it while stalled; lat is the cycle stall drops (or flush cycle).
  task automatic do_op(input logic [7:0] i_inst, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h, input int dly, input int flush_at,
                       output int lat, output int wes, output logic [63:0] data,
                       output int aborts, output int starts);
    lat = -1; wes = 0; data = 64'd0; aborts = 0; starts = 0;
    div_delay = dly;
    @(negedge clk);
    inst = i_inst; inst_valid = 1'b1; op1 = a; op2 = b; hilo_i = h;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      exception_flush = (k == flush_at);
      #1;
      wes    += int'(hilo_we_o);
      aborts += int'(div_abort_o);
      starts += int'(div_start_o);
      if (k == flush_at) begin lat = k; break; end
      if (!stall_o) begin lat = k; data = hilo_o; break; end
    end
  endtask

  task automatic idle(input int n, output int ev);
    ev = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      inst_valid = 1'b0; exception_flush = 1'b0;
      #1;
      ev += int'(hilo_we_o) + int'(div_abort_o) + int'(stall_o) + int'(div_start_o);
    end
  endtask

  initial begin
    int lat, wes, aborts, starts, ev, base;
    logic [63:0] data;

    rst = 1'b1; exception_flush = 1'b0; inst = 8'h00; inst_valid = 1'b0;
    op1 = 32'd0; op2 = 32'd0; hilo_i = 64'd0;

    vecs.push_back('{`INST_MULT,  32'hFFFFFFFD, 32'd5, 64'd0, 0, -1, 3, 1, 64'hFFFFFFFF_FFFFFFF1, 0, 0});
    vecs.push_back('{`INST_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 0, -1, 3, 1, 64'hFFFFFFFE_00000001, 0, 0});
    vecs.push_back('{`INST_MULT,  32'h80000000, 32'h80000000, 64'd0, 0, -1, 3, 1, 64'h40000000_00000000, 0, 0});
    vecs.push_back('{`INST_MULT,  32'd7, 32'hFFFFFFFE, 64'd0, 0, -1, 3, 1, 64'hFFFFFFFF_FFFFFFF2, 0, 0});
    vecs.push_back('{`INST_MULTU, 32'h80000000, 32'd2, 64'd0, 0, -1, 3, 1, 64'h00000001_00000000, 0, 0});
    vecs.push_back('{`INST_DIVU,  32'd100, 32'd7, 64'd0, 36, -1, 38, 1, 64'h00000002_0000000E, 0, 1});
    vecs.push_back('{`INST_DIV,   32'hFFFFFFF9, 32'd2, 64'd0, 3, -1, 5, 1, 64'hFFFFFFFF_FFFFFFFD, 0, 1});
    vecs.push_back('{`INST_DIV,   32'd7, 32'hFFFFFFFE, 64'd0, 1, -1, 3, 1, 64'h00000001_FFFFFFFD, 0, 1});
    vecs.push_back('{`INST_DIVU,  32'hFFFFFFF9, 32'd2, 64'd0, 2, -1, 4, 1, 64'h00000001_7FFFFFFC, 0, 1});
    vecs.push_back('{`INST_DIVU,  32'd5, 32'd0, 64'd0, 5, -1, 1, 0, 64'd0, 0, 0});
    vecs.push_back('{`INST_DIV,   32'hFFFFFFF9, 32'd0, 64'd0, 5, -1, 1, 0, 64'd0, 0, 0});
    vecs.push_back('{`INST_DIVU,  32'd10, 32'd3, 64'd0, 100, -1, 38, 0, 64'd0, 1, 1});
    vecs.push_back('{`INST_DIVU,  32'd50, 32'd5, 64'd0, 20, 10, 10, 0, 64'd0, 1, 1});
    vecs.push_back('{`INST_MULT,  32'd3, 32'd3, 64'd0, 0, 1, 1, 0, 64'd0, 0, 0});
`ifdef MULDIV_ACC_EN
    vecs.push_back('{`INST_MADD,  32'd2, 32'd3, 64'h00000001_00000000, 0, -1, 4, 1, 64'h00000001_00000006, 0, 0});
    vecs.push_back('{`INST_MSUBU, 32'd1, 32'd1, 64'd0, 0, -1, 4, 1, 64'hFFFFFFFF_FFFFFFFF, 0, 0});
    vecs.push_back('{`INST_MSUB,  32'hFFFFFFFF, 32'd3, 64'd0, 0, -1, 4, 1, 64'h00000000_00000003, 0, 0});
    vecs.push_back('{`INST_MADDU, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 0, -1, 4, 1, 64'd0, 0, 0});
`else
    vecs.push_back('{`INST_MADD,  32'd2, 32'd3, 64'h00000001_00000000, 0, -1, 0, 0, 64'd0, 0, 0});
    vecs.push_back('{`INST_MSUBU, 32'd1, 32'd1, 64'd0, 0, -1, 0, 0, 64'd0, 0, 0});
`endif

    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", {59'd0, busy_o, stall_o, hilo_we_o, div_start_o, div_abort_o}, 64'd0);
    check("rst_hilo", hilo_o, 64'd0);
    check("rst_ops", {mul_a_o, div_d_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].dly, vecs[i].flush_at,
            lat, wes, data, aborts, starts);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_we", i), 64'(wes), 64'(vecs[i].exp_we));
      if (vecs[i].exp_we != 0) check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("v%0d_abort", i), 64'(aborts), 64'(vecs[i].exp_abort));
      check($sformatf("v%0d_start", i), 64'(starts), 64'(vecs[i].exp_start));
      // Long quiet period lets any late divider done arrive while IDLE.
      idle(70, ev);
      check($sformatf("v%0d_post", i), {63'd0, busy_o} + 64'(ev), 64'd0);
    end

    // Back-to-back MULT then DIVU: second accepted right after DONE, one write each.
    base = we_count;
    do_op(`INST_MULT, 32'd3, 32'd4, 64'd0, 0, -1, lat, wes, data, aborts, starts);
    check("b2b_mul_lat", 64'(lat), 64'd3);
    check("b2b_mul_data", data, 64'h00000000_0000000C);
    do_op(`INST_DIVU, 32'd9, 32'd2, 64'd0, 2, -1, lat, wes, data, aborts, starts);
    check("b2b_div_lat", 64'(lat), 64'd4);
    check("b2b_div_data", data, 64'h00000001_00000004);
    idle(10, ev);
    check("b2b_writes", 64'(we_count - base), 64'd2);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    inst = `INST_MULTU; inst_valid = 1'b1; op1 = 32'd2; op2 = 32'd3;
    @(negedge clk);
    inst_valid = 1'b0;
    #1;
    check("mid_busy", {63'd0, busy_o}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst", {mul_a_o, 27'd0, busy_o, stall_o, hilo_we_o, div_start_o, div_abort_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(5, ev);
    check("mid_post", {63'd0, busy_o} + 64'(ev), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
